// File: rtl/conv2d_control_unit.sv
// conv2d_control_unit
// Sequencer in front of convolution_top. It runs one layer:
//   1. load the kernel words,
//   2. stream every input channel while accumulating with read-modify-write,
//   3. drain the finished output.
// It only counts handshake beats and never sees data.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start                      layer start pulse, sampled only in IDLE
//   Image_size, Channel_size   layer geometry, latched when start is accepted
//   kernel_wr_beat             one kernel word accepted (LOAD_KERNEL only)
//   in_beat                    one input pixel accepted (CONV only)
//   acc_wr_en                  one accumulated pixel written back (CONV/FLUSH)
//   out_beat                   one 64-bit output beat accepted (DRAIN only)
//   Load_kernel_BRAM           high while the kernel is being loaded
//   kernel_BRAM_counter_out    kernel word address, then the current channel
//   window_BRAM_counter_out    line-buffer column of the last accepted pixel
//   a_/b_output_BRAM_counter_out  accumulation write/read address
//                              (b counts output beats while draining)
//   in_row_counter/in_col_counter  position of the next input pixel
//   drain_active, drain_last   drain phase, and final drain beat pending
//   busy, done, cfg_err        status; done and cfg_err are one-cycle pulses
//
// Optional build macro CONV_CTRL_PERF_EN adds perf_stall_cycles[31:0].
// It counts idle cycles in CONV and in DRAIN.

module conv2d_control_unit #(
  parameter int ACC_LAT = 3,
  parameter int MAX_IMG = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  Image_size,
  input  logic [8:0]  Channel_size,
  input  logic        kernel_wr_beat,
  input  logic        in_beat,
  input  logic        acc_wr_en,
  input  logic        out_beat,
  output logic        Load_kernel_BRAM,
  output logic [7:0]  kernel_BRAM_counter_out,
  output logic [6:0]  window_BRAM_counter_out,
  output logic [13:0] a_output_BRAM_counter_out,
  output logic [13:0] b_output_BRAM_counter_out,
  output logic [7:0]  in_row_counter,
  output logic [7:0]  in_col_counter,
  output logic        drain_active,
  output logic        drain_last,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  // The lag counter must hold the worst-case distance between reads and
  // write-backs at the end of a layer.
  localparam int LAG_W = $clog2(ACC_LAT + MAX_IMG + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KERNEL,
    S_CONV,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  img_q, img_d;
  logic [8:0]  ch_q, ch_d;
  logic        load_q, load_d;
  logic [7:0]  kcnt_q, kcnt_d;
  logic [6:0]  win_q, win_d;
  logic [13:0] a_q, a_d;
  logic [13:0] b_q, b_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [LAG_W-1:0] lag_q, lag_d;
  logic        drain_active_q, drain_active_d;
  logic        drain_last_q, drain_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
`endif

  logic [7:0]  img_last;
  logic [7:0]  ch_last;
  logic [14:0] img_sq;
  logic [13:0] pix_last;
  logic [13:0] beat_last;
  logic        img_ok;
  logic        ch_ok;
  logic        lag_inc;
  logic        lag_dec;

  // Terminal values derived from the latched geometry.
  // Image_size^2 needs 15 bits so that 128*128 does not alias to 0.
  always_comb begin
    img_last  = img_q - 8'd1;
    ch_last   = 8'(ch_q - 9'd1);
    img_sq    = 15'(img_q) * 15'(img_q);
    pix_last  = 14'(img_sq - 15'd1);
    beat_last = 14'((img_sq >> 2) - 15'd1);
  end

  // Legality of the requested geometry, checked only when start arrives.
  always_comb begin
    img_ok = 1'b0;
    ch_ok  = 1'b0;
    case (Image_size)
      8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128: img_ok = 1'b1;
      default:                                 img_ok = 1'b0;
    endcase
    if ({24'd0, Image_size} > 32'(MAX_IMG)) img_ok = 1'b0;
    case (Channel_size)
      9'd64, 9'd128, 9'd256: ch_ok = 1'b1;
      default:               ch_ok = 1'b0;
    endcase
  end

  // Outstanding read-modify-writes.
  // Reads are counted on in_beat and write-backs on acc_wr_en.
  // FLUSH waits for this to reach zero.
  always_comb begin
    lag_inc = (state_q == S_CONV) && in_beat;
    lag_dec = ((state_q == S_CONV) || (state_q == S_FLUSH)) && acc_wr_en &&
              ((lag_q != '0) || lag_inc);
  end

  always_comb begin
    state_d        = state_q;
    img_d          = img_q;
    ch_d           = ch_q;
    load_d         = load_q;
    kcnt_d         = kcnt_q;
    win_d          = win_q;
    a_d            = a_q;
    b_d            = b_q;
    row_d          = row_q;
    col_d          = col_q;
    lag_d          = lag_q;
    drain_active_d = drain_active_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    cfg_err_d      = 1'b0;
`ifdef CONV_CTRL_PERF_EN
    perf_d         = perf_q;
`endif

    case ({lag_inc, lag_dec})
      2'b10:   lag_d = lag_q + LAG_W'(1);
      2'b01:   lag_d = lag_q - LAG_W'(1);
      default: lag_d = lag_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (img_ok && ch_ok) begin
            state_d = S_LOAD_KERNEL;
            img_d   = Image_size;
            ch_d    = Channel_size;
            load_d  = 1'b1;
            busy_d  = 1'b1;
`ifdef CONV_CTRL_PERF_EN
            perf_d  = '0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_LOAD_KERNEL: begin
        if (kernel_wr_beat) begin
          // For 256 channels the terminal word is 255.
          // The 8-bit counter wraps to 0 on its own there.
          if (kcnt_q == ch_last) begin
            kcnt_d  = '0;
            load_d  = 1'b0;
            state_d = S_CONV;
          end else begin
            kcnt_d = kcnt_q + 8'd1;
          end
        end
      end

      S_CONV: begin
        if (in_beat) begin
          win_d = col_q[6:0];
          b_d   = (b_q == pix_last) ? '0 : b_q + 14'd1;
          if (col_q == img_last) begin
            col_d = '0;
            row_d = (row_q == img_last) ? '0 : row_q + 8'd1;
            if (row_q == img_last) begin
              // Last pixel of a channel: advance to the next kernel.
              if (kcnt_q == ch_last) begin
                kcnt_d  = '0;
                state_d = S_FLUSH;
              end else begin
                kcnt_d = kcnt_q + 8'd1;
              end
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end

      S_FLUSH: begin
        // Every read of the final channel must be written back
        // before the accumulation BRAM can be drained.
        if ((a_q == '0) && (lag_q == '0)) begin
          b_d            = '0;
          drain_active_d = 1'b1;
          state_d        = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (out_beat) begin
          if (drain_last_q) begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            drain_active_d = 1'b0;
            img_d          = '0;
            ch_d           = '0;
            kcnt_d         = '0;
            win_d          = '0;
            a_d            = '0;
            b_d            = '0;
            row_d          = '0;
            col_d          = '0;
            lag_d          = '0;
          end else begin
            b_d = b_q + 14'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // The write address advances through CONV and through the FLUSH tail.
    if (((state_q == S_CONV) || (state_q == S_FLUSH)) && acc_wr_en) begin
      a_d = (a_q == pix_last) ? '0 : a_q + 14'd1;
    end

    // Registered from the next-state values.
    // drain_last is therefore high exactly while b sits on the final beat.
    drain_last_d = (state_d == S_DRAIN) && (b_d == beat_last);

`ifdef CONV_CTRL_PERF_EN
    if ((((state_q == S_CONV) && !in_beat) || ((state_q == S_DRAIN) && !out_beat)) &&
        (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      img_q          <= '0;
      ch_q           <= '0;
      load_q         <= 1'b0;
      kcnt_q         <= '0;
      win_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      row_q          <= '0;
      col_q          <= '0;
      lag_q          <= '0;
      drain_active_q <= 1'b0;
      drain_last_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
`ifdef CONV_CTRL_PERF_EN
      perf_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      img_q          <= img_d;
      ch_q           <= ch_d;
      load_q         <= load_d;
      kcnt_q         <= kcnt_d;
      win_q          <= win_d;
      a_q            <= a_d;
      b_q            <= b_d;
      row_q          <= row_d;
      col_q          <= col_d;
      lag_q          <= lag_d;
      drain_active_q <= drain_active_d;
      drain_last_q   <= drain_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
`ifdef CONV_CTRL_PERF_EN
      perf_q         <= perf_d;
`endif
    end
  end

  assign Load_kernel_BRAM          = load_q;
  assign kernel_BRAM_counter_out   = kcnt_q;
  assign window_BRAM_counter_out   = win_q;
  assign a_output_BRAM_counter_out = a_q;
  assign b_output_BRAM_counter_out = b_q;
  assign in_row_counter            = row_q;
  assign in_col_counter            = col_q;
  assign drain_active              = drain_active_q;
  assign drain_last                = drain_last_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign cfg_err                   = cfg_err_q;
`ifdef CONV_CTRL_PERF_EN
  assign perf_stall_cycles         = perf_q;
`endif

endmodule

// File: tb/tb_conv2d_control_unit.sv
// Testbench for conv2d_control_unit.
// Inputs change just after the falling edge; outputs are sampled at the
// falling edge. The accumulation write-back is modelled as each in_beat
// echoed on acc_wr_en three cycles later.

module tb_conv2d_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  image_size;
  logic [8:0]  channel_size;
  logic        kernel_wr_beat;
  logic        in_beat;
  logic        acc_wr_en;
  logic        out_beat;
  logic        Load_kernel_BRAM;
  logic [7:0]  kernel_BRAM_counter_out;
  logic [6:0]  window_BRAM_counter_out;
  logic [13:0] a_output_BRAM_counter_out;
  logic [13:0] b_output_BRAM_counter_out;
  logic [7:0]  in_row_counter;
  logic [7:0]  in_col_counter;
  logic        drain_active;
  logic        drain_last;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Write-back delay line and the number of write-backs issued so far.
  logic [2:0] acc_hist   = '0;
  int         acc_writes = 0;

  always #5 clk = ~clk;

  conv2d_control_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .Image_size                (image_size),
    .Channel_size              (channel_size),
    .kernel_wr_beat            (kernel_wr_beat),
    .in_beat                   (in_beat),
    .acc_wr_en                 (acc_wr_en),
    .out_beat                  (out_beat),
    .Load_kernel_BRAM          (Load_kernel_BRAM),
    .kernel_BRAM_counter_out   (kernel_BRAM_counter_out),
    .window_BRAM_counter_out   (window_BRAM_counter_out),
    .a_output_BRAM_counter_out (a_output_BRAM_counter_out),
    .b_output_BRAM_counter_out (b_output_BRAM_counter_out),
    .in_row_counter            (in_row_counter),
    .in_col_counter            (in_col_counter),
    .drain_active              (drain_active),
    .drain_last                (drain_last),
    .busy                      (busy),
    .done                      (done),
    .cfg_err                   (cfg_err)
`ifdef CONV_CTRL_PERF_EN
    ,
    .perf_stall_cycles         (perf_stall_cycles)
`endif
  );

  // One clock of streaming. The write-back for an in_beat appears
  // three steps later on acc_wr_en.
  task automatic step(input logic beat_in, input logic beat_out);
    in_beat   = beat_in;
    out_beat  = beat_out;
    acc_wr_en = acc_hist[2];
    if (acc_hist[2]) acc_writes++;
    acc_hist  = {acc_hist[1:0], beat_in};
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; image_size = '0; channel_size = '0;
    kernel_wr_beat = 1'b0; in_beat = 1'b0; acc_wr_en = 1'b0; out_beat = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_compared++;
    if ({Load_kernel_BRAM, kernel_BRAM_counter_out, window_BRAM_counter_out,
         a_output_BRAM_counter_out, b_output_BRAM_counter_out, in_row_counter,
         in_col_counter, drain_active, drain_last, busy, done, cfg_err} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: busy=%b load=%b kcnt=%0d a=%0d b=%0d, required all 0",
               busy, Load_kernel_BRAM, kernel_BRAM_counter_out,
               a_output_BRAM_counter_out, b_output_BRAM_counter_out);
    end
  endtask

  task automatic test_cfg_err;
    // Illegal Image_size. Stray beats in IDLE must be ignored as well.
    image_size = 8'd12; channel_size = 9'd64; start = 1'b1;
    kernel_wr_beat = 1'b1; in_beat = 1'b1; out_beat = 1'b1; acc_wr_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_compared++;
    if ({cfg_err, busy, kernel_BRAM_counter_out, a_output_BRAM_counter_out,
         b_output_BRAM_counter_out, in_col_counter} !== {1'b1, 1'b0, 44'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_img: cfg_err=%b busy=%b kcnt=%0d a=%0d b=%0d col=%0d, required 1 0 0 0 0 0",
               cfg_err, busy, kernel_BRAM_counter_out, a_output_BRAM_counter_out,
               b_output_BRAM_counter_out, in_col_counter);
    end
    @(negedge clk);
    n_compared++;
    if ({cfg_err, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_pulse: cfg_err=%b busy=%b, required 0 0", cfg_err, busy);
    end
    // Illegal Channel_size.
    image_size = 8'd4; channel_size = 9'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_compared++;
    if ({cfg_err, busy, Load_kernel_BRAM} !== 3'b100) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_ch: cfg_err=%b busy=%b load=%b, required 1 0 0",
               cfg_err, busy, Load_kernel_BRAM);
    end
    kernel_wr_beat = 1'b0; in_beat = 1'b0; out_beat = 1'b0; acc_wr_en = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({cfg_err, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL cfg_err_clear: cfg_err=%b busy=%b, required 0 0", cfg_err, busy);
    end
  endtask

  // Accept a start, then corrupt the size inputs.
  // The DUT must run on the latched copy.
  task automatic start_layer(input int img, input int ch);
    acc_hist = '0; acc_writes = 0;
    image_size = 8'(img); channel_size = 9'(ch); start = 1'b1;
    @(negedge clk);
    start = 1'b0; image_size = 8'd12; channel_size = 9'd100;
    n_compared++;
    if ({busy, Load_kernel_BRAM, kernel_BRAM_counter_out} !== {1'b1, 1'b1, 8'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL start_accept: busy=%b load=%b kcnt=%0d, required 1 1 0",
               busy, Load_kernel_BRAM, kernel_BRAM_counter_out);
    end
  endtask

  task automatic test_kernel_load(input int ch);
    kernel_wr_beat = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({Load_kernel_BRAM, kernel_BRAM_counter_out} !== {1'b1, 8'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL kload_hold: load=%b kcnt=%0d, required 1 0",
               Load_kernel_BRAM, kernel_BRAM_counter_out);
    end
    for (int i = 0; i < ch; i++) begin
      int   exp_k;
      logic exp_load;
      kernel_wr_beat = 1'b1;
      @(negedge clk);
      exp_k    = (i + 1 == ch) ? 0 : i + 1;
      exp_load = (i + 1 != ch);
      n_compared++;
      if (kernel_BRAM_counter_out !== 8'(exp_k) || Load_kernel_BRAM !== exp_load) begin
        n_mismatched++;
        $display("[TB] FAIL kload beat %0d: kcnt=%0d load=%b, required %0d %b",
                 i, kernel_BRAM_counter_out, Load_kernel_BRAM, exp_k, exp_load);
      end
    end
    kernel_wr_beat = 1'b0;
  endtask

  // Stream one full channel. With gaps set, it also drives one stray
  // out_beat and inserts one idle cycle.
  task automatic test_conv_channel(input int img, input int c, input int ch_total, input bit gaps);
    int sq = img * img;
    for (int p = 0; p < sq; p++) begin
      int exp_col, exp_row, exp_win, exp_b, exp_a;
      step(1'b1, gaps && (p == 2));
      if (gaps && (p == 5)) step(1'b0, 1'b0);
      exp_col = (p + 1) % img;
      exp_row = ((p + 1) / img) % img;
      exp_win = p % img;
      exp_b   = (p + 1) % sq;
      exp_a   = acc_writes % sq;
      n_compared++;
      if ({in_row_counter, in_col_counter, window_BRAM_counter_out,
           b_output_BRAM_counter_out, a_output_BRAM_counter_out} !==
          {8'(exp_row), 8'(exp_col), 7'(exp_win), 14'(exp_b), 14'(exp_a)}) begin
        n_mismatched++;
        $display("[TB] FAIL conv_pos ch %0d px %0d: row/col/win/b/a=%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                 c, p, in_row_counter, in_col_counter, window_BRAM_counter_out,
                 b_output_BRAM_counter_out, a_output_BRAM_counter_out,
                 exp_row, exp_col, exp_win, exp_b, exp_a);
      end
    end
    if (c + 1 < ch_total) begin
      n_compared++;
      if (kernel_BRAM_counter_out !== 8'(c + 1)) begin
        n_mismatched++;
        $display("[TB] FAIL conv_channel_idx ch %0d: kcnt=%0d, required %0d",
                 c, kernel_BRAM_counter_out, c + 1);
      end
    end else begin
      n_compared++;
      if ({busy, drain_active} !== 2'b10) begin
        n_mismatched++;
        $display("[TB] FAIL conv_to_flush: busy=%b drain_active=%b, required 1 0",
                 busy, drain_active);
      end
    end
  endtask

  task automatic test_flush_drain(input int img);
    int quarter = img * img / 4;
    // The final three write-backs are still in flight. DRAIN may start
    // only on the cycle after the last of them.
    for (int s = 1; s <= 4; s++) begin
      logic exp_da;
      step(1'b0, 1'b0);
      exp_da = (s == 4);
      n_compared++;
      if (drain_active !== exp_da) begin
        n_mismatched++;
        $display("[TB] FAIL flush_wait step %0d: drain_active=%b, required %b",
                 s, drain_active, exp_da);
      end
    end
    n_compared++;
    if ({a_output_BRAM_counter_out, b_output_BRAM_counter_out, busy, drain_last} !==
        {14'd0, 14'd0, 1'b1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL drain_entry: a=%0d b=%0d busy=%b last=%b, required 0 0 1 0",
               a_output_BRAM_counter_out, b_output_BRAM_counter_out, busy, drain_last);
    end
    for (int k = 0; k < quarter; k++) begin
      logic exp_last;
      if (k == 1) step(1'b0, 1'b0);
      exp_last = (k == quarter - 1);
      n_compared++;
      if ({b_output_BRAM_counter_out, drain_last, done} !== {14'(k), exp_last, 1'b0}) begin
        n_mismatched++;
        $display("[TB] FAIL drain_beat %0d: b=%0d last=%b done=%b, required %0d %b 0",
                 k, b_output_BRAM_counter_out, drain_last, done, k, exp_last);
      end
      step(1'b0, 1'b1);
    end
    n_compared++;
    if ({done, busy, drain_active, drain_last, b_output_BRAM_counter_out,
         a_output_BRAM_counter_out, kernel_BRAM_counter_out, in_row_counter,
         in_col_counter} !== {1'b1, 1'b1, 2'b00, 52'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL done_pulse: done=%b busy=%b da=%b b=%0d a=%0d kcnt=%0d, required 1 1 0 0 0 0",
               done, busy, drain_active, b_output_BRAM_counter_out,
               a_output_BRAM_counter_out, kernel_BRAM_counter_out);
    end
    step(1'b0, 1'b0);
    n_compared++;
    if ({done, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL done_to_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_full_layer(input int img, input int ch, input bit gaps);
    $display("[TB] layer Image_size=%0d Channel_size=%0d", img, ch);
    start_layer(img, ch);
    test_kernel_load(ch);
    for (int c = 0; c < ch; c++) test_conv_channel(img, c, ch, gaps && (c == 0));
    test_flush_drain(img);
`ifdef CONV_CTRL_PERF_EN
    n_compared++;
    if (perf_stall_cycles !== 32'(gaps ? 2 : 1)) begin
      n_mismatched++;
      $display("[TB] FAIL perf_stall: got %0d, required %0d", perf_stall_cycles, gaps ? 2 : 1);
    end
`endif
  endtask

  task automatic test_reset_mid_conv;
    start_layer(4, 64);
    test_kernel_load(64);
    for (int p = 0; p < 9; p++) step(1'b1, 1'b0);
    n_compared++;
    if ({in_row_counter, in_col_counter} !== {8'd2, 8'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL mid_conv_pos: row=%0d col=%0d, required 2 1",
               in_row_counter, in_col_counter);
    end
    reset = 1'b1; in_beat = 1'b0; acc_wr_en = 1'b0; out_beat = 1'b0;
    @(negedge clk);
    reset = 1'b0; acc_hist = '0; acc_writes = 0;
    n_compared++;
    if ({Load_kernel_BRAM, kernel_BRAM_counter_out, window_BRAM_counter_out,
         a_output_BRAM_counter_out, b_output_BRAM_counter_out, in_row_counter,
         in_col_counter, drain_active, drain_last, busy, done, cfg_err} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b row=%0d col=%0d b=%0d a=%0d, required all 0",
               busy, done, in_row_counter, in_col_counter,
               b_output_BRAM_counter_out, a_output_BRAM_counter_out);
    end
    @(negedge clk);
    n_compared++;
    if ({busy, done} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_no_done: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Largest geometry: the kernel counter wraps 255->0, and b runs to 16383
  // and wraps over one full channel.
  task automatic test_large_image;
    $display("[TB] large image: Image_size=128 Channel_size=256, first channel");
    start_layer(128, 256);
    test_kernel_load(256);
    test_conv_channel(128, 0, 256, 1'b0);
    reset = 1'b1; in_beat = 1'b0; acc_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; acc_hist = '0; acc_writes = 0;
    n_compared++;
    if ({busy, b_output_BRAM_counter_out, kernel_BRAM_counter_out} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL large_reset: busy=%b b=%0d kcnt=%0d, required 0 0 0",
               busy, b_output_BRAM_counter_out, kernel_BRAM_counter_out);
    end
  endtask

  initial begin
    test_reset;
    test_cfg_err;
    test_full_layer(4, 64, 1'b1);
    test_full_layer(8, 64, 1'b0);
    test_reset_mid_conv;
    test_full_layer(4, 64, 1'b0);
    test_large_image;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
